// File: rtl/adc_pkg.sv
// rtl/adc_pkg.sv - shared types and frame layout for the ADC capture block
// Purpose: FSM state enum, serial frame geometry and a window helper.
// Ports: none (package).
package adc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CONV  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } adc_state_e;

  localparam int FRAME_BITS = 34;
  localparam int CH0_FIRST  = 2;
  localparam int CH1_FIRST  = 18;
  localparam int SAMPLE_W   = 14;
  localparam int PERIOD_W   = 6;

  // True when the sck period number falls inside a channel's data window.
  function automatic logic in_window(input logic [PERIOD_W-1:0] period, input int first);
    return (int'(period) >= first) && (int'(period) < first + SAMPLE_W);
  endfunction

endpackage

// File: rtl/adc_capture_if.sv
// rtl/adc_capture_if.sv - serial wires between the capture block and the ADC
// Purpose: bundles the ADC-side serial bus.
// Ports (signals): spi_sck, ad_conv driven by master; adc_out driven by slave (ADC).
interface adc_capture_if;
  logic spi_sck;
  logic ad_conv;
  logic adc_out;

  modport master (output spi_sck, output ad_conv, input adc_out);
  modport slave  (input spi_sck, input ad_conv, output adc_out);
endinterface

// File: rtl/sck_gen.sv
// rtl/sck_gen.sv - serial clock phase generator for one ADC frame
// Purpose: while en_i is high, produces spi_sck (low DIV, high DIV per period,
//          starting low), a strobe on the cycle whose edge raises sck, and the
//          running period number; everything clears when en_i is low.
// Ports: clk_i, rst_i (async, active-high), en_i;
//        sck_o, rise_o, last_o (final cycle of period FRAME_BITS-1), period_o.
module sck_gen
  import adc_pkg::*;
#(
  parameter int DIV = 1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                en_i,
  output logic                sck_o,
  output logic                rise_o,
  output logic                last_o,
  output logic [PERIOD_W-1:0] period_o
);

  localparam logic [7:0]          DIV_M1      = 8'(DIV - 1);
  localparam logic [PERIOD_W-1:0] LAST_PERIOD = PERIOD_W'(FRAME_BITS - 1);

  logic [7:0]          cnt_q, cnt_d;
  logic                sck_q, sck_d;
  logic [PERIOD_W-1:0] period_q, period_d;
  logic                tc;

  assign tc      = (cnt_q == DIV_M1);
  assign rise_o  = en_i & tc & ~sck_q;
  assign last_o  = en_i & tc & sck_q & (period_q == LAST_PERIOD);
  assign sck_o   = sck_q;
  assign period_o = period_q;

  always_comb begin
    cnt_d    = cnt_q;
    sck_d    = sck_q;
    period_d = period_q;
    if (!en_i) begin
      cnt_d    = '0;
      sck_d    = 1'b0;
      period_d = '0;
    end else if (tc) begin
      cnt_d = '0;
      if (sck_q) begin
        // Falling edge closes a period; the last one wraps to a clean state.
        sck_d    = 1'b0;
        period_d = last_o ? '0 : period_q + 1'b1;
      end else begin
        sck_d = 1'b1;
      end
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q    <= '0;
      sck_q    <= 1'b0;
      period_q <= '0;
    end else begin
      cnt_q    <= cnt_d;
      sck_q    <= sck_d;
      period_q <= period_d;
    end
  end

endmodule

// File: rtl/adc_capture.sv
// rtl/adc_capture.sv - two-channel serial ADC frame capture with start arbitration
// Purpose: on adc_trig (when the shared preamp bus is idle) pulses ad_conv for
//          2*DIV cycles, clocks a 34-period frame, captures both channels and
//          publishes them with a one-cycle adc_done.
// Ports: CLK50MHZ, RST (async, active-high); spi_sck, ad_conv, adc_out (ADC);
//        bus_busy, adc_trig (inputs); adc_busy, adc_done, adc_ch0, adc_ch1.
// Config: define ADC_CAPTURE_CONT_EN for back-to-back frames from DONE.
module adc_capture
  import adc_pkg::*;
#(
  parameter int DIV   = 1,
  parameter int WIDTH = 14
) (
  input  logic             CLK50MHZ,
  input  logic             RST,
  output logic             spi_sck,
  output logic             ad_conv,
  input  logic             adc_out,
  input  logic             bus_busy,
  input  logic             adc_trig,
  output logic             adc_busy,
  output logic             adc_done,
  output logic [WIDTH-1:0] adc_ch0,
  output logic [WIDTH-1:0] adc_ch1
);

  localparam logic [8:0] CONV_LAST = 9'(2 * DIV - 1);

  adc_state_e          state_q, state_d;
  logic [8:0]          conv_cnt_q, conv_cnt_d;
  logic [WIDTH-1:0]    sh0_q, sh0_d, sh1_q, sh1_d;
  logic [WIDTH-1:0]    ch0_q, ch0_d, ch1_q, ch1_d;
  logic                busy_q, conv_q, done_q;
  logic                sck_en, sck_rise, frame_end;
  logic [PERIOD_W-1:0] period;

  assign sck_en = (state_q == SHIFT);

  sck_gen #(.DIV(DIV)) u_sck_gen (
    .clk_i   (CLK50MHZ),
    .rst_i   (RST),
    .en_i    (sck_en),
    .sck_o   (spi_sck),
    .rise_o  (sck_rise),
    .last_o  (frame_end),
    .period_o(period)
  );

  always_comb begin
    state_d    = state_q;
    conv_cnt_d = '0;
    sh0_d      = sh0_q;
    sh1_d      = sh1_q;
    ch0_d      = ch0_q;
    ch1_d      = ch1_q;
    case (state_q)
      IDLE: begin
        if (adc_trig && !bus_busy) state_d = CONV;
      end
      CONV: begin
        sh0_d      = '0;
        sh1_d      = '0;
        conv_cnt_d = conv_cnt_q + 1'b1;
        if (conv_cnt_q == CONV_LAST) begin
          conv_cnt_d = '0;
          state_d    = SHIFT;
        end
      end
      SHIFT: begin
        // adc_out is taken on the edge that raises spi_sck.
        if (sck_rise && in_window(period, CH0_FIRST)) sh0_d = {sh0_q[WIDTH-2:0], adc_out};
        if (sck_rise && in_window(period, CH1_FIRST)) sh1_d = {sh1_q[WIDTH-2:0], adc_out};
        if (frame_end) begin
          state_d = DONE;
          // Outputs change only here, so a partial frame is never visible.
          ch0_d   = sh0_q;
          ch1_d   = sh1_q;
        end
      end
      DONE: begin
`ifdef ADC_CAPTURE_CONT_EN
        if (adc_trig && !bus_busy) state_d = CONV;
        else                       state_d = IDLE;
`else
        state_d = IDLE;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK50MHZ or posedge RST) begin
    if (RST) begin
      state_q    <= IDLE;
      conv_cnt_q <= '0;
      sh0_q      <= '0;
      sh1_q      <= '0;
      ch0_q      <= '0;
      ch1_q      <= '0;
      busy_q     <= 1'b0;
      conv_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      conv_cnt_q <= conv_cnt_d;
      sh0_q      <= sh0_d;
      sh1_q      <= sh1_d;
      ch0_q      <= ch0_d;
      ch1_q      <= ch1_d;
      // Status flags are decoded from the next state so they line up with it.
      busy_q     <= (state_d != IDLE);
      conv_q     <= (state_d == CONV);
      done_q     <= (state_d == DONE);
    end
  end

  assign ad_conv  = conv_q;
  assign adc_busy = busy_q;
  assign adc_done = done_q;
  assign adc_ch0  = ch0_q;
  assign adc_ch1  = ch1_q;

endmodule

// File: tb/tb_adc_capture.sv
// tb/tb_adc_capture.sv - directed self-checking bench for adc_capture
module tb_adc_capture;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        trig1 = 1'b0, bb1 = 1'b0, trig3 = 1'b0;
  logic        busy1, done1, busy3, done3;
  logic [13:0] ch0_1, ch1_1, ch0_3, ch1_3;
  logic [13:0] m0_1 = '0, m1_1 = '0, m0_3 = '0, m1_3 = '0;
  int          checks = 0;
  int          errors = 0;

`ifdef ADC_CAPTURE_CONT_EN
  localparam int EXP_GAP = 1;
`else
  localparam int EXP_GAP = 2;
`endif

  adc_capture_if bus1 ();
  adc_capture_if bus3 ();

  always #10 clk = ~clk;

  adc_capture #(.DIV(1)) u_dut1 (
    .CLK50MHZ(clk), .RST(rst),
    .spi_sck(bus1.spi_sck), .ad_conv(bus1.ad_conv), .adc_out(bus1.adc_out),
    .bus_busy(bb1), .adc_trig(trig1),
    .adc_busy(busy1), .adc_done(done1), .adc_ch0(ch0_1), .adc_ch1(ch1_1)
  );

  adc_capture #(.DIV(3)) u_dut3 (
    .CLK50MHZ(clk), .RST(rst),
    .spi_sck(bus3.spi_sck), .ad_conv(bus3.ad_conv), .adc_out(bus3.adc_out),
    .bus_busy(1'b0), .adc_trig(trig3),
    .adc_busy(busy3), .adc_done(done3), .adc_ch0(ch0_3), .adc_ch1(ch1_3)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Frame bit for sck period idx; ignored periods carry 1 to expose misalignment.
  function automatic logic frame_bit(input logic [13:0] a, input logic [13:0] b, input int idx);
    logic [3:0] k;
    if (idx >= 2 && idx <= 15) begin
      k = 4'(15 - idx);
      return a[k];
    end else if (idx >= 18 && idx <= 31) begin
      k = 4'(31 - idx);
      return b[k];
    end
    return 1'b1;
  endfunction

  // ADC models: period 0 starts at ad_conv fall, each sck fall starts the next.
  logic p_sck1 = 1'b0, p_conv1 = 1'b0, p_sck3 = 1'b0, p_conv3 = 1'b0;
  int   idx1 = 0, idx3 = 0;
  always @(negedge clk) begin
    if (p_conv1 && !bus1.ad_conv)     idx1 = 0;
    else if (p_sck1 && !bus1.spi_sck) idx1 = idx1 + 1;
    bus1.adc_out = frame_bit(m0_1, m1_1, idx1);
    p_sck1  = bus1.spi_sck;
    p_conv1 = bus1.ad_conv;
  end
  always @(negedge clk) begin
    if (p_conv3 && !bus3.ad_conv)     idx3 = 0;
    else if (p_sck3 && !bus3.spi_sck) idx3 = idx3 + 1;
    bus3.adc_out = frame_bit(m0_3, m1_3, idx3);
    p_sck3  = bus3.spi_sck;
    p_conv3 = bus3.ad_conv;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, convs, busy_at1, dones, early, rises, g;
    int run, run_min, run_max, nruns;
    logic armed, ps, pc, s, c;

    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy1), 32'd0);
    check("rst_done", 32'(done1), 32'd0);
    check("rst_sck",  32'(bus1.spi_sck), 32'd0);
    check("rst_conv", 32'(bus1.ad_conv), 32'd0);
    check("rst_ch0",  32'(ch0_1), 32'd0);
    check("rst_ch1",  32'(ch1_1), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Basic frame, DIV=1.
    m0_1 = 14'h1ABC; m1_1 = 14'h2543;
    trig1 = 1'b1; n = 0; convs = 0; busy_at1 = 0;
    while (n < 200) begin
      @(negedge clk); n++; trig1 = 1'b0;
      if (n == 1) busy_at1 = int'(busy1);
      if (bus1.ad_conv) convs++;
      if (done1) break;
    end
    check("lat_div1", 32'(n), 32'd71);
    check("busy_in_frame", 32'(busy_at1), 32'd1);
    check("conv_len_div1", 32'(convs), 32'd2);
    check("ch0_div1", 32'(ch0_1), 32'h1ABC);
    check("ch1_div1", 32'(ch1_1), 32'h2543);
    @(negedge clk);
    check("done_one_cycle", 32'(done1), 32'd0);
    check("idle_busy", 32'(busy1), 32'd0);
    repeat (5) @(negedge clk);
    check("ch0_hold", 32'(ch0_1), 32'h1ABC);

    // DIV=3 geometry.
    m0_3 = 14'h3FFF; m1_3 = 14'h0000;
    trig3 = 1'b1; n = 0; convs = 0; rises = 0; armed = 1'b0;
    run = 0; run_min = 1000; run_max = 0; nruns = 0; ps = 1'b0; pc = 1'b0;
    while (n < 400) begin
      @(negedge clk); n++; trig3 = 1'b0;
      s = bus3.spi_sck; c = bus3.ad_conv;
      if (c) convs++;
      if (pc && !c) begin armed = 1'b1; run = 0; end
      if (armed) begin
        if (s != ps) begin
          nruns++;
          if (run < run_min) run_min = run;
          if (run > run_max) run_max = run;
          run = 1;
          if (s) rises++;
        end else begin
          run++;
        end
      end
      ps = s; pc = c;
      if (done3) break;
    end
    check("lat_div3", 32'(n), 32'd211);
    check("conv_len_div3", 32'(convs), 32'd6);
    check("sck_rises", 32'(rises), 32'd34);
    check("sck_phases", 32'(nruns), 32'd68);
    check("phase_min", 32'(run_min), 32'd3);
    check("phase_max", 32'(run_max), 32'd3);
    check("ch0_div3", 32'(ch0_3), 32'h3FFF);
    check("ch1_div3", 32'(ch1_3), 32'h0000);

    // Start arbitration against bus_busy, and no stall when it rises mid-frame.
    m0_1 = 14'h0555; m1_1 = 14'h3AAA;
    bb1 = 1'b1; trig1 = 1'b1; convs = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus1.ad_conv || busy1) convs++;
    end
    check("no_start_bus_busy", 32'(convs), 32'd0);
    bb1 = 1'b0;
    @(negedge clk);
    check("conv_after_bus_free", 32'(bus1.ad_conv), 32'd1);
    trig1 = 1'b0; n = 1;
    while (n < 200) begin
      @(negedge clk); n++;
      if (n == 10) bb1 = 1'b1;
      if (done1) break;
    end
    bb1 = 1'b0;
    check("lat_bus_busy_mid", 32'(n), 32'd71);
    check("ch0_bb", 32'(ch0_1), 32'h0555);
    check("ch1_bb", 32'(ch1_1), 32'h3AAA);

    // Second trigger during SHIFT is ignored; outputs stay stable until done.
    m0_1 = 14'h2222; m1_1 = 14'h1111;
    trig1 = 1'b1; dones = 0; early = 0;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk);
      trig1 = (i == 30);
      if (done1) dones++;
      if (dones == 0 && (ch0_1 != 14'h0555 || ch1_1 != 14'h3AAA)) early++;
    end
    trig1 = 1'b0;
    check("single_done", 32'(dones), 32'd1);
    check("no_partial_out", 32'(early), 32'd0);
    check("ch0_retrig", 32'(ch0_1), 32'h2222);
    check("ch1_retrig", 32'(ch1_1), 32'h1111);

    // Held trigger: gap from adc_done to the next ad_conv.
    m0_1 = 14'h0A5A; m1_1 = 14'h15A5;
    trig1 = 1'b1;
    for (int f = 0; f < 3; f++) begin
      n = 0;
      while (n < 200) begin
        @(negedge clk); n++;
        if (done1) break;
      end
      check("held_trig_done", 32'(done1), 32'd1);
      if (f < 2) begin
        g = 0;
        while (g < 10) begin
          @(negedge clk); g++;
          if (bus1.ad_conv) break;
        end
        check("done_to_conv_gap", 32'(g), 32'(EXP_GAP));
      end
    end
    trig1 = 1'b0;
    check("ch0_cont", 32'(ch0_1), 32'h0A5A);
    check("ch1_cont", 32'(ch1_1), 32'h15A5);
    repeat (5) @(negedge clk);
    check("idle_after_cont", 32'(busy1), 32'd0);

    // Reset during sck period 10 (its rise is the 11th).
    trig1 = 1'b1; rises = 0; ps = 1'b0; n = 0;
    while (n < 200) begin
      @(negedge clk); n++; trig1 = 1'b0;
      if (!ps && bus1.spi_sck) rises++;
      ps = bus1.spi_sck;
      if (rises == 11) break;
    end
    check("reached_period10", 32'(rises), 32'd11);
    rst = 1'b1;
    #1;
    check("arst_sck",  32'(bus1.spi_sck), 32'd0);
    check("arst_conv", 32'(bus1.ad_conv), 32'd0);
    check("arst_busy", 32'(busy1), 32'd0);
    check("arst_done", 32'(done1), 32'd0);
    check("arst_ch0",  32'(ch0_1), 32'd0);
    check("arst_ch1",  32'(ch1_1), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    dones = 0; convs = 0;
    repeat (150) begin
      @(negedge clk);
      if (done1) dones++;
      if (busy1) convs++;
    end
    check("no_done_after_rst", 32'(dones), 32'd0);
    check("no_restart_after_rst", 32'(convs), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/adc_capture.md
ADC_CAPTURE -- requirements
Module: adc_capture

Interface
REQ-001 SHALL have parameter DIV, default 1, meaning spi_sck half-period in CLK50MHZ cycles (legal range 1..255).
REQ-002 SHALL have parameter WIDTH, default 14, meaning the sample width per channel.
REQ-003 SHALL have port CLK50MHZ, input, 1 bit: the single clock; all logic on its rising edge.
REQ-004 SHALL have port RST, input, 1 bit: reset, asynchronous and active-high.
REQ-005 SHALL have port spi_sck, output, 1 bit: serial clock to the ADC, shared with the preamp bus.
REQ-006 SHALL have port ad_conv, output, 1 bit: conversion start strobe to the ADC.
REQ-007 SHALL have port adc_out, input, 1 bit: serial data from the ADC.
REQ-008 SHALL have port bus_busy, input, 1 bit: the preamp SPI transfer is in progress.
REQ-009 SHALL have port adc_trig, input, 1 bit: level request to start one conversion.
REQ-010 SHALL have port adc_busy, output, 1 bit: a frame is in progress.
REQ-011 SHALL have port adc_done, output, 1 bit: one-cycle completion pulse.
REQ-012 SHALL have ports adc_ch0 and adc_ch1, output, WIDTH bits each: two's-complement channel samples.

Function
REQ-013 SHALL implement the FSM states IDLE, CONV, SHIFT and DONE.
REQ-014 IDLE->CONV SHALL occur when adc_trig=1 and bus_busy=0; otherwise the FSM SHALL stay in IDLE.
REQ-015 In CONV, ad_conv SHALL be 1 for exactly 2*DIV cycles and spi_sck SHALL be 0; the FSM SHALL then go to SHIFT.
REQ-016 In SHIFT, the block SHALL generate exactly 34 spi_sck periods (low DIV, high DIV, starting low), numbered 0..33, with ad_conv=0.
REQ-017 adc_out SHALL be sampled on the CLK50MHZ edge that drives spi_sck 0->1.
REQ-018 Periods 2..15 SHALL fill ch0 MSB-first; periods 18..31 SHALL fill ch1 MSB-first; periods 0, 1, 16, 17, 32 and 33 SHALL be ignored.
REQ-019 After period 33, the FSM SHALL enter DONE for one cycle: adc_done=1, and adc_ch0/adc_ch1 SHALL be loaded from the shift registers in that same cycle.
REQ-020 adc_ch0/adc_ch1 SHALL hold their values between completions; partial frames SHALL never appear on them.
REQ-021 Trigger-to-done latency SHALL be 1+2*DIV+68*DIV cycles (DIV=1: 71 cycles).
REQ-022 adc_busy SHALL be 1 in CONV, SHIFT and DONE, and 0 in IDLE.
REQ-023 adc_trig SHALL be ignored while adc_busy=1.
REQ-024 bus_busy rising mid-frame SHALL NOT stall or abort the frame; arbitration is applied at start only.
REQ-025 DONE->IDLE SHALL occur unconditionally, except as given in REQ-030.

Reset
REQ-026 RST=1 SHALL asynchronously force: state IDLE, spi_sck=0, ad_conv=0, adc_busy=0, adc_done=0, adc_ch0=0, adc_ch1=0, counters 0.
REQ-027 A reset asserted mid-frame SHALL abandon the frame with no adc_done and no output update.
REQ-028 After RST deasserts, the first conversion SHALL start only on a new qualifying adc_trig.

Configuration
REQ-029 Macro ADC_CAPTURE_CONT_EN SHALL select continuous mode.
REQ-030 With ADC_CAPTURE_CONT_EN defined: DONE->CONV directly when adc_trig=1 and bus_busy=0, giving back-to-back frames every 2*DIV+68*DIV+1 cycles; otherwise DONE->IDLE.
REQ-031 Without ADC_CAPTURE_CONT_EN: DONE->IDLE always, and a held adc_trig SHALL restart only from IDLE (one extra idle cycle between frames).

Structure
REQ-032 Package adc_pkg SHALL hold the state enum, FRAME_BITS=34, CH0_FIRST=2, CH1_FIRST=18 and SAMPLE_W=14.
REQ-033 Sub-module sck_gen SHALL produce the spi_sck phase, a rise strobe and a period counter from DIV and an enable.
REQ-034 adc_capture SHALL contain the FSM, the shift registers and the output registers.

Verification
REQ-035 Reset, then DIV=1, adc_trig pulse, ADC model returns ch0=0x1ABC and ch1=0x2543 -> adc_done at cycle 71; adc_ch0=0x1ABC, adc_ch1=0x2543.
REQ-036 DIV=3, ch0=0x3FFF, ch1=0x0000 -> exactly 34 sck rises, each sck phase 3 cycles, ad_conv high 6 cycles, outputs correct.
REQ-037 adc_trig=1 with bus_busy=1 for 20 cycles -> no ad_conv; bus_busy drops -> CONV begins the next cycle.
REQ-038 RST asserted at sck period 10 -> all outputs 0 immediately, no adc_done, previous samples cleared.
REQ-039 adc_trig held high for 3 frames -> with ADC_CAPTURE_CONT_EN, done-to-next-ad_conv gap is 1 cycle; without it, the gap is 2 cycles.
REQ-040 Second adc_trig pulse mid-SHIFT -> ignored; exactly one adc_done is produced.
